// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer, ALU decoder and condition unit for the multicycle ARMv4-subset datapath.
module multicycle_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] Instr,
   input  logic [3:0]  ALUFlags,
   input  logic        MemReady,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ImmSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUControl,
   output logic [1:0]  ResultSrc,
   output logic [3:0]  State
);
   localparam logic [3:0] FETCH  = 4'd0;
   localparam logic [3:0] DECODE = 4'd1;
   localparam logic [3:0] MEMADR = 4'd2;
   localparam logic [3:0] MEMRD  = 4'd3;
   localparam logic [3:0] MEMWB  = 4'd4;
   localparam logic [3:0] MEMWR  = 4'd5;
   localparam logic [3:0] EXECR  = 4'd6;
   localparam logic [3:0] EXECI  = 4'd7;
   localparam logic [3:0] ALUWB  = 4'd8;
   localparam logic [3:0] BRANCH = 4'd9;

   logic [3:0] state, next;
   logic [3:0] flags;
   logic       condq, condex;
   logic [1:0] op, alu_dec;
   logic [5:0] funct;
   logic [3:0] cond;
   logic       known, exec, wr_nz, wr_cv;
   logic       pcw, irw, rw, mw;
   logic       n, z, c, v;

   assign cond  = Instr[19:16];
   assign op    = Instr[15:14];
   assign funct = Instr[13:8];
   assign {n, z, c, v} = flags;

   always_comb begin
      next = FETCH;
      case (state)
         FETCH:   next = MemReady ? DECODE : FETCH;
         DECODE:  next = (op == 2'b01) ? MEMADR :
                         (op == 2'b10) ? BRANCH :
                         (op == 2'b11) ? FETCH  :
                         funct[5]      ? EXECI  : EXECR;
         MEMADR:  next = funct[0] ? MEMRD : MEMWR;
         MEMRD:   next = MemReady ? MEMWB : MEMRD;
         MEMWR:   next = MemReady ? FETCH : MEMWR;
         EXECR:   next = ALUWB;
         EXECI:   next = ALUWB;
         default: next = FETCH;
      endcase
   end

   always_comb begin
      known   = 1'b1;
      alu_dec = 2'b00;
      case (funct[4:1])
         4'b0100: alu_dec = 2'b00;
         4'b0010: alu_dec = 2'b01;
         4'b0000: alu_dec = 2'b10;
         4'b1100: alu_dec = 2'b11;
         default: known = 1'b0;
      endcase
   end

   always_comb begin
      condex = 1'b0;
      case (cond)
         4'b0000: condex = z;
         4'b0001: condex = ~z;
         4'b0010: condex = c;
         4'b0011: condex = ~c;
         4'b0100: condex = n;
         4'b0101: condex = ~n;
         4'b0110: condex = v;
         4'b0111: condex = ~v;
         4'b1000: condex = c & ~z;
         4'b1001: condex = ~c | z;
         4'b1010: condex = (n == v);
         4'b1011: condex = (n != v);
         4'b1100: condex = ~z & (n == v);
         4'b1101: condex = z | (n != v);
         4'b1110: condex = 1'b1;
         default: condex = 1'b0;
      endcase
   end

   // Carry/overflow only mean something for arithmetic ops, so logic ops leave them alone.
   assign exec  = (state == EXECR) | (state == EXECI);
   assign wr_nz = exec & condq & funct[0] & known;
   assign wr_cv = wr_nz & ~alu_dec[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         flags <= 4'b0000;
         condq <= 1'b0;
      end else begin
         state <= next;
         if (state == DECODE) condq <= condex;
         if (wr_nz) flags[3:2] <= ALUFlags[3:2];
         if (wr_cv) flags[1:0] <= ALUFlags[1:0];
      end
   end

   always_comb begin
      pcw        = 1'b0;
      irw        = 1'b0;
      rw         = 1'b0;
      mw         = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = 2'b00;
      ResultSrc  = 2'b00;
      case (state)
         FETCH: begin
            irw       = MemReady;
            pcw       = MemReady;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         MEMADR:  ALUSrcB = 2'b01;
         MEMRD:   AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc = 2'b01;
            rw        = condq;
         end
         MEMWR: begin
            AdrSrc = 1'b1;
            mw     = condq;
         end
         EXECR:   ALUControl = alu_dec;
         EXECI: begin
            ALUSrcB    = 2'b01;
            ALUControl = alu_dec;
         end
         ALUWB: begin
            rw  = condq;
            pcw = condq & (Instr[3:0] == 4'hF);
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            pcw       = condq;
         end
         default: ;
      endcase
   end

   // Strobes are suppressed during reset so an aborted access never writes.
   assign PCWrite  = ~reset & pcw;
   assign IRWrite  = ~reset & irw;
   assign RegWrite = ~reset & rw;
   assign MemWrite = ~reset & mw;
   assign ImmSrc   = op;
   assign RegSrc   = {(op == 2'b01) & ~funct[0], op == 2'b10};
   assign State    = state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven cycle-by-cycle check of multicycle_ctrl plus cycle-count sequences.
module tb_multicycle_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        MemReady;
   logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
   logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;
   logic [3:0]  State;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc), .State(State)
   );

   always #5 clk = ~clk;

   localparam logic [19:0] ADDS  = 20'hE2921;
   localparam logic [19:0] BEQ   = 20'h0A000;
   localparam logic [19:0] BNE   = 20'h1A000;
   localparam logic [19:0] LDR   = 20'hE5903;
   localparam logic [19:0] STRNE = 20'h15802;
   localparam logic [19:0] ADDPC = 20'hE28FF;
   localparam logic [19:0] ORRS  = 20'hE1900;
   localparam logic [19:0] BMI   = 20'h4A000;
   localparam logic [19:0] BCS   = 20'h2A000;
   localparam logic [19:0] NOP   = 20'hEC000;
   localparam logic [19:0] STR   = 20'hE5802;
   localparam logic [19:0] B     = 20'hEA000;

   typedef struct {
      logic        rst;
      logic [19:0] instr;
      logic [3:0]  flg;
      logic        rdy;
      logic [14:0] exp;
   } vec_t;

   vec_t v[$];
   int   tests = 0;
   int   fails = 0;

   // exp packs {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcB, ALUControl}
   function automatic vec_t mk(logic rst, logic [19:0] instr, logic [3:0] flg, logic rdy,
                               logic [3:0] st, logic [3:0] we, logic adr,
                               logic [1:0] rs, logic [1:0] sb, logic [1:0] ac);
      vec_t r;
      r.rst = rst; r.instr = instr; r.flg = flg; r.rdy = rdy;
      r.exp = {st, we, adr, rs, sb, ac};
      return r;
   endfunction

   task automatic run_instr(input logic [19:0] instr, input int cyc, input logic [3:0] src, input string name);
      int n;
      Instr = instr;
      MemReady = 1'b1;
      ALUFlags = 4'b0000;
      #1;
      tests++;
      if ({ImmSrc, RegSrc} !== src) begin
         fails++;
         $display("FAIL %s_src: got %b required %b", name, {ImmSrc, RegSrc}, src);
      end
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (State != 4'd0 && n < 20);
      tests++;
      if (n != cyc) begin
         fails++;
         $display("FAIL %s_cycles: got %0d required %0d", name, n, cyc);
      end
   endtask

   initial begin
      v.push_back(mk(1, 0,     0, 1, 0, 4'b0000, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, ADDS,  0, 1, 0, 4'b1100, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, ADDS,  0, 1, 1, 4'b0000, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, ADDS,  4'b0100, 1, 7, 4'b0000, 0, 2'b00, 2'b01, 2'b00));
      v.push_back(mk(0, ADDS,  0, 1, 8, 4'b0010, 0, 2'b00, 2'b00, 2'b00));
      v.push_back(mk(0, BEQ,   0, 1, 0, 4'b1100, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, BEQ,   0, 1, 1, 4'b0000, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, BEQ,   0, 1, 9, 4'b1000, 0, 2'b10, 2'b01, 2'b00));
      v.push_back(mk(0, BNE,   0, 1, 0, 4'b1100, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, BNE,   0, 1, 1, 4'b0000, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, BNE,   0, 1, 9, 4'b0000, 0, 2'b10, 2'b01, 2'b00));
      v.push_back(mk(0, LDR,   0, 1, 0, 4'b1100, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, LDR,   0, 1, 1, 4'b0000, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, LDR,   0, 1, 2, 4'b0000, 0, 2'b00, 2'b01, 2'b00));
      for (int i = 0; i < 3; i++)
         v.push_back(mk(0, LDR, 0, 0, 3, 4'b0000, 1, 2'b00, 2'b00, 2'b00));
      v.push_back(mk(0, LDR,   0, 1, 3, 4'b0000, 1, 2'b00, 2'b00, 2'b00));
      v.push_back(mk(0, LDR,   0, 1, 4, 4'b0010, 0, 2'b01, 2'b00, 2'b00));
      v.push_back(mk(0, STRNE, 0, 0, 0, 4'b0000, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, STRNE, 0, 1, 0, 4'b1100, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, STRNE, 0, 1, 1, 4'b0000, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, STRNE, 0, 1, 2, 4'b0000, 0, 2'b00, 2'b01, 2'b00));
      v.push_back(mk(0, STRNE, 0, 1, 5, 4'b0000, 1, 2'b00, 2'b00, 2'b00));
      v.push_back(mk(0, ADDPC, 0, 1, 0, 4'b1100, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, ADDPC, 0, 1, 1, 4'b0000, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, ADDPC, 4'b1111, 1, 7, 4'b0000, 0, 2'b00, 2'b01, 2'b00));
      v.push_back(mk(0, ADDPC, 0, 1, 8, 4'b1010, 0, 2'b00, 2'b00, 2'b00));
      v.push_back(mk(0, ORRS,  0, 1, 0, 4'b1100, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, ORRS,  0, 1, 1, 4'b0000, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, ORRS,  4'b1011, 1, 6, 4'b0000, 0, 2'b00, 2'b00, 2'b11));
      v.push_back(mk(0, ORRS,  0, 1, 8, 4'b0010, 0, 2'b00, 2'b00, 2'b00));
      v.push_back(mk(0, BMI,   0, 1, 0, 4'b1100, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, BMI,   0, 1, 1, 4'b0000, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, BMI,   0, 1, 9, 4'b1000, 0, 2'b10, 2'b01, 2'b00));
      v.push_back(mk(0, BCS,   0, 1, 0, 4'b1100, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, BCS,   0, 1, 1, 4'b0000, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, BCS,   0, 1, 9, 4'b0000, 0, 2'b10, 2'b01, 2'b00));
      v.push_back(mk(0, NOP,   0, 1, 0, 4'b1100, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, NOP,   0, 1, 1, 4'b0000, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, STR,   0, 1, 0, 4'b1100, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, STR,   0, 1, 1, 4'b0000, 0, 2'b10, 2'b10, 2'b00));
      v.push_back(mk(0, STR,   0, 1, 2, 4'b0000, 0, 2'b00, 2'b01, 2'b00));
      v.push_back(mk(0, STR,   0, 0, 5, 4'b0001, 1, 2'b00, 2'b00, 2'b00));
      v.push_back(mk(0, STR,   0, 0, 5, 4'b0001, 1, 2'b00, 2'b00, 2'b00));
      v.push_back(mk(1, STR,   0, 0, 5, 4'b0000, 1, 2'b00, 2'b00, 2'b00));
      v.push_back(mk(0, STR,   0, 1, 0, 4'b1100, 0, 2'b10, 2'b10, 2'b00));

      reset = 1'b1; Instr = '0; ALUFlags = '0; MemReady = 1'b1;
      @(posedge clk); #1;
      foreach (v[i]) begin
         reset = v[i].rst; Instr = v[i].instr; ALUFlags = v[i].flg; MemReady = v[i].rdy;
         @(negedge clk);
         tests++;
         if ({State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcB, ALUControl} !== v[i].exp) begin
            fails++;
            $display("FAIL vec%0d: got %b required %b", i,
                     {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcB, ALUControl}, v[i].exp);
         end
         @(posedge clk); #1;
      end

      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      run_instr(B,   3, 4'b1001, "b");
      run_instr(ADDS, 4, 4'b0000, "dp");
      run_instr(STR, 4, 4'b0110, "str");
      run_instr(LDR, 5, 4'b0100, "ldr");
      run_instr(NOP, 2, 4'b1100, "nop");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencer for the ARMv4-subset core: it replaces the single-cycle controller so one shared memory and one ALU can serve fetch, address generation, PC increment and execute. A Moore FSM, an ALU decoder and condition logic with registered flags drive the mux selects and write enables of a multicycle datapath. It tolerates variable memory latency through a ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- Instr  in  20  instruction register bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- MemReady  in  1  memory done for the current access
- PCWrite  out  1  PC register load enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU output register
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register load enable
- RegWrite  out  1  register file write enable
- RegSrc  out  2  [0]: RA1 = R15; [1]: RA2 = Rd
- ImmSrc  out  2  same encoding as extend: 00 imm8, 01 imm12, 10 branch
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 = register B, 01 = ExtImm, 10 = constant 4
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ResultSrc  out  2  00 = ALU output register, 01 = data register, 10 = ALU result (direct)
- State  out  4  current FSM state, for debug

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Codes 10–15 go to FETCH on the next edge.
- Transitions:
  - FETCH to DECODE when MemReady, else stay.
  - DECODE by Op: 01 to MEMADR; 00 with Funct[5]=1 to EXECI; 00 with Funct[5]=0 to EXECR; 10 to BRANCH; 11 to FETCH (NOP).
  - MEMADR to MEMRD if Funct[0]=1 (LDR), else MEMWR.
  - MEMRD to MEMWB when MemReady; MEMWB to FETCH.
  - MEMWR to FETCH when MemReady.
  - EXECR and EXECI to ALUWB; ALUWB to FETCH; BRANCH to FETCH.
- Per-state outputs. Anything not listed is 0.
  - FETCH: AdrSrc 0, IRWrite=MemReady, ALUSrcA 1, ALUSrcB 10, ALU ADD, ResultSrc 10, PCWrite=MemReady.
  - DECODE: ALUSrcA 1, ALUSrcB 10, ADD, ResultSrc 10.
  - MEMADR: ALUSrcB 01, ADD.
  - MEMRD: AdrSrc 1.
  - MEMWB: ResultSrc 01, RegWrite=CondQ.
  - MEMWR: AdrSrc 1, MemWrite=CondQ.
  - EXECR: ALUSrcB 00, ALU decoded.
  - EXECI: ALUSrcB 01, ALU decoded.
  - ALUWB: RegWrite=CondQ, PCWrite=CondQ & (Rd==15).
  - BRANCH: ALUSrcB 01, ADD, ResultSrc 10, PCWrite=CondQ.
- ALU decode by Funct[4:1]:
  - 0100 gives ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - Any other value gives ADD with flags not written.
  - S bit = Funct[0]. N and Z are written on S. C and V are written on S & (ADD|SUB).
- Combinational decode, independent of state:
  - ImmSrc = Op.
  - RegSrc[0] = (Op==10).
  - RegSrc[1] = (Op==01 & Funct[0]==0).
- Condition evaluation:
  - CondEx is evaluated in DECODE from the registered Flags using the standard ARM cond table. Cond 1111 gives CondEx=0.
  - CondEx is latched into CondQ on the DECODE edge.
  - CondQ gates every later write for that instruction. Flags written in EXECR/EXECI only when CondQ=1.
  - Flags change only on that EXECR/EXECI edge, so flags are never read in the same instruction after they are written.

## Timing
- Reset (synchronous, on edge with reset=1): State=FETCH, Flags=0000, CondQ=0. The next cycle drives the FETCH outputs.
- Cycles per instruction with MemReady held at 1:
  - B: 3
  - DP: 4
  - STR: 4
  - LDR: 5
  - Op=11: 2
- Each cycle MemReady is low in FETCH, MEMRD or MEMWR adds one cycle.
  - While waiting, IRWrite and PCWrite stay 0.
  - MemWrite stays asserted throughout MEMWR.
- Failed condition: the instruction takes the same cycle count with no RegWrite, MemWrite, flag or branch effect. The PC increment in FETCH is still taken.
- Reset mid-instruction: State=FETCH on the next edge, and all strobes are 0 in the reset cycle itself.
- No output is driven X in any state.

## Test plan
- Reset held 2 cycles then released, MemReady=1:
  - State=0, PCWrite=1, IRWrite=1 in the first cycle.
  - State=1 in the next cycle.
- ADDS R1,R2,#5 (Instr[31:12]=E2921), ALUFlags=0100 in EXECI:
  - States 0,1,7,8,0.
  - RegWrite=1 only in ALUWB.
  - Flags become Z=1.
  - A following BEQ (Cond 0000) gives PCWrite=1 in BRANCH.
- LDR with MemReady low for 3 cycles in MEMRD:
  - States 0,1,2,3,3,3,3,4,0.
  - RegWrite=1 once, in MEMWB; ResultSrc=01 there.
- STR, Cond NE, with Z=1:
  - States 0,1,2,5,0.
  - MemWrite stays 0 throughout.
- DP with Rd=15 (ADD PC,PC,#0):
  - PCWrite=1 and RegWrite=1 in ALUWB.
- Reset asserted while in MEMWR with MemReady low:
  - MemWrite=0 in the reset cycle.
  - State=0 afterwards.
